// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and helpers for the parametrised UART receiver
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_status_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// uart_rx_param_if : received-word handshake and status bundle
// Rev 1.0
// ============================================================================
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 break_det;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err, break_det,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err, break_det,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
// uart_bit_sampler : rx synchroniser, tick counter and 3-sample majority vote
// Rev 1.0
// ============================================================================
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic bd_tick,
  input  logic rx,
  input  logic hold,
  output logic rx_s,
  output logic rx_prev,
  output logic bit_value,
  output logic bit_decide,
  output logic bit_end
);

  localparam int             TW     = $clog2(OVS);
  localparam logic [TW-1:0]  SMP0   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0]  SMP1   = TW'(OVS/2);
  localparam logic [TW-1:0]  SMP2   = TW'(OVS/2 + 1);
  localparam logic [TW-1:0]  LAST   = TW'(OVS - 1);

  logic          sync1;
  logic          sync2;
  logic          smp0;
  logic          smp1;
  logic [TW-1:0] tick_cnt;

  // Synchroniser presets to 1 so the idle line never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_prev  <= 1'b1;
      smp0     <= 1'b1;
      smp1     <= 1'b1;
      tick_cnt <= '0;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      if (bd_tick) begin
        rx_prev  <= sync2;
        tick_cnt <= hold ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == SMP0) smp0 <= sync2;
        if (tick_cnt == SMP1) smp1 <= sync2;
      end
    end
  end

  assign rx_s       = sync2;
  assign bit_value  = maj3(smp0, smp1, sync2);
  assign bit_decide = bd_tick && !hold && (tick_cnt == SMP2);
  assign bit_end    = bd_tick && !hold && (tick_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// uart_rx_param : parametrised UART receiver with valid/ready word delivery
// Rev 1.0
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bd_tick,
  input  logic                rx,
  uart_rx_param_if.master     rx_if
);

  localparam int BC_W = $clog2(DATA_BITS + 1);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [BC_W-1:0]      bit_cnt;
  logic                 stop_cnt;
  logic                 pbit;
  rx_status_t           st;

  logic rx_s;
  logic rx_prev;
  logic bit_value;
  logic bit_decide;
  logic bit_end;
  logic idle_hold;
  logic par_bad;
  logic last_stop;
  logic is_break;
  logic stop_fail;

  assign idle_hold = (state == ST_IDLE);

  uart_bit_sampler #(
    .OVS (OVS)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .bd_tick    (bd_tick),
    .rx         (rx),
    .hold       (idle_hold),
    .rx_s       (rx_s),
    .rx_prev    (rx_prev),
    .bit_value  (bit_value),
    .bit_decide (bit_decide),
    .bit_end    (bit_end)
  );

  assign par_bad   = (PARITY == PAR_ODD) ? ~(^shreg ^ bit_value) : (^shreg ^ bit_value);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  // Break is judged on the first stop bit; pbit stays 0 when no parity bit exists.
  assign is_break  = (shreg == '0) && !pbit && !bit_value && !stop_cnt;
  assign stop_fail = st.frame_err | ~bit_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      shreg             <= '0;
      bit_cnt           <= '0;
      stop_cnt          <= 1'b0;
      pbit              <= 1'b0;
      st                <= '0;
      rx_if.rx_data     <= '0;
      rx_if.rx_valid    <= 1'b0;
      rx_if.parity_err  <= 1'b0;
      rx_if.frame_err   <= 1'b0;
      rx_if.overrun_err <= 1'b0;
      rx_if.break_det   <= 1'b0;
    end else begin
      rx_if.overrun_err <= 1'b0;
      rx_if.break_det   <= 1'b0;
      if (rx_if.rx_valid && rx_if.rx_ready) rx_if.rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bd_tick && rx_prev && !rx_s) begin
            state    <= ST_START;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            pbit     <= 1'b0;
            st       <= '0;
          end
        end
        ST_START: begin
          if (bit_decide && bit_value) state <= ST_IDLE;
          else if (bit_end)            state <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_decide) begin
            shreg   <= {bit_value, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BC_W'(DATA_BITS - 1))
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (bit_decide) begin
            pbit          <= bit_value;
            st.parity_err <= par_bad;
            state         <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_decide) begin
            if (is_break) begin
              rx_if.break_det <= 1'b1;
              state           <= ST_WAIT_IDLE;
            end else if (!last_stop) begin
              stop_cnt <= 1'b1;
              if (!bit_value) st.frame_err <= 1'b1;
            end else begin
              // A word accepted this same cycle frees the holding register.
              if (!rx_if.rx_valid || rx_if.rx_ready) begin
                rx_if.rx_data    <= shreg;
                rx_if.rx_valid   <= 1'b1;
                rx_if.parity_err <= st.parity_err;
                rx_if.frame_err  <= stop_fail;
              end else begin
                rx_if.overrun_err <= 1'b1;
              end
              state <= stop_fail ? ST_WAIT_IDLE : ST_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (bit_decide && bit_value) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_param : scoreboard bench over 8N1, 8O1 and 9N2 receivers
// Rev 1.0
// ============================================================================
module tb_uart_rx_param;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bd_tick = 1'b0;
  logic [1:0] div = 2'd0;
  logic       rx_line [3];

  exp_t q [3][$];
  int   acc_cnt [3];
  int   brk_cnt [3];
  int   ovr_cnt [3];
  int   total = 0;
  int   bad = 0;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifb ();
  uart_rx_param_if #(.DATA_BITS(9)) ifc ();

  uart_rx_param #(.DATA_BITS(8), .OVS(16), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .rx(rx_line[0]), .rx_if(ifa));
  uart_rx_param #(.DATA_BITS(8), .OVS(16), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .rx(rx_line[1]), .rx_if(ifb));
  uart_rx_param #(.DATA_BITS(9), .OVS(16), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .rx(rx_line[2]), .rx_if(ifc));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div     <= div + 2'd1;
    bd_tick <= (div == 2'd3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic score(input int ln, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    acc_cnt[ln]++;
    if (q[ln].size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_word line%0d: got %0h want none", ln, d);
    end else begin
      e = q[ln].pop_front();
      check($sformatf("data%0d", ln), 32'(d), 32'(e.d));
      check($sformatf("parity_err%0d", ln), 32'(pe), 32'(e.pe));
      check($sformatf("frame_err%0d", ln), 32'(fe), 32'(e.fe));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.rx_valid && ifa.rx_ready) score(0, 9'(ifa.rx_data), ifa.parity_err, ifa.frame_err);
      if (ifb.rx_valid && ifb.rx_ready) score(1, 9'(ifb.rx_data), ifb.parity_err, ifb.frame_err);
      if (ifc.rx_valid && ifc.rx_ready) score(2, ifc.rx_data, ifc.parity_err, ifc.frame_err);
      if (ifa.break_det)   brk_cnt[0]++;
      if (ifb.break_det)   brk_cnt[1]++;
      if (ifc.break_det)   brk_cnt[2]++;
      if (ifa.overrun_err) ovr_cnt[0]++;
      if (ifb.overrun_err) ovr_cnt[1]++;
      if (ifc.overrun_err) ovr_cnt[2]++;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bd_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic bit_out(input int ln, input logic v);
    rx_line[ln] = v;
    wait_ticks(16);
  endtask

  task automatic send(input int ln, input logic [8:0] d, input int nb, input int par,
                      input logic pb, input int ns, input logic s1, input logic s2);
    bit_out(ln, 1'b0);
    for (int i = 0; i < nb; i++) bit_out(ln, d[i]);
    if (par != 0) bit_out(ln, pb);
    bit_out(ln, s1);
    if (ns == 2) bit_out(ln, s2);
    bit_out(ln, 1'b1);
  endtask

  task automatic expect_word(input int ln, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    q[ln].push_back(e);
  endtask

  initial begin
    #800000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_line[i] = 1'b1;
      acc_cnt[i] = 0;
      brk_cnt[i] = 0;
      ovr_cnt[i] = 0;
    end
    ifa.rx_ready = 1'b1;
    ifb.rx_ready = 1'b1;
    ifc.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data_a",  32'(ifa.rx_data), 32'h0);
    check("rst_valid_a", 32'(ifa.rx_valid), 32'h0);
    check("rst_perr_a",  32'(ifa.parity_err), 32'h0);
    check("rst_ferr_a",  32'(ifa.frame_err), 32'h0);
    check("rst_ovr_a",   32'(ifa.overrun_err), 32'h0);
    check("rst_brk_a",   32'(ifa.break_det), 32'h0);
    check("rst_valid_c", 32'(ifc.rx_valid), 32'h0);
    rst = 1'b0;
    wait_ticks(32);

    // 8N1 clean frame
    expect_word(0, 9'h0A5, 1'b0, 1'b0);
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1);

    // 8O1: 0x5A has four ones, so the correct odd parity bit is 1
    expect_word(1, 9'h05A, 1'b1, 1'b0);
    send(1, 9'h05A, 8, 1, 1'b0, 1, 1'b1, 1'b1);
    expect_word(1, 9'h05A, 1'b0, 1'b0);
    send(1, 9'h05A, 8, 1, 1'b1, 1, 1'b1, 1'b1);

    // 9N2 with bad second stop, then a clean frame after one idle bit
    expect_word(2, 9'h1C3, 1'b0, 1'b1);
    send(2, 9'h1C3, 9, 0, 1'b0, 2, 1'b1, 1'b0);
    expect_word(2, 9'h055, 1'b0, 1'b0);
    send(2, 9'h055, 9, 0, 1'b0, 2, 1'b1, 1'b1);

    // short low glitch must not produce anything
    rx_line[0] = 1'b0;
    wait_ticks(4);
    rx_line[0] = 1'b1;
    wait_ticks(32);
    check("glitch_words", 32'(acc_cnt[0]), 32'd1);
    check("glitch_valid", 32'(ifa.rx_valid), 32'h0);
    check("glitch_brk",   32'(brk_cnt[0]), 32'd0);

    // overrun: second word dropped, first held
    ifa.rx_ready = 1'b0;
    expect_word(0, 9'h011, 1'b0, 1'b0);
    send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1);
    check("ovr_pulses", 32'(ovr_cnt[0]), 32'd1);
    check("ovr_held",   32'(ifa.rx_data), 32'h11);
    ifa.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_consumed", 32'(acc_cnt[0]), 32'd2);
    check("ovr_valid_low", 32'(ifa.rx_valid), 32'h0);

    // break frame
    send(0, 9'h000, 8, 0, 1'b0, 1, 1'b0, 1'b1);
    bit_out(0, 1'b1);
    check("brk_pulses", 32'(brk_cnt[0]), 32'd1);
    check("brk_words",  32'(acc_cnt[0]), 32'd2);

    // reset in the middle of the data bits
    bit_out(0, 1'b0);
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    bit_out(0, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_data",  32'(ifa.rx_data), 32'h0);
    check("mid_rst_valid", 32'(ifa.rx_valid), 32'h0);
    check("mid_rst_ferr",  32'(ifa.frame_err), 32'h0);
    rx_line[0] = 1'b1;
    rst = 1'b0;
    wait_ticks(32);
    expect_word(0, 9'h03C, 1'b0, 1'b0);
    send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 1'b1);

    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("left%0d", i), 32'(q[i].size()), 32'd0);
    end
    check("words_a", 32'(acc_cnt[0]), 32'd3);
    check("words_b", 32'(acc_cnt[1]), 32'd2);
    check("words_c", 32'(acc_cnt[2]), 32'd2);
    check("brk_b",   32'(brk_cnt[1]), 32'd0);
    check("brk_c",   32'(brk_cnt[2]), 32'd0);
    check("ovr_c",   32'(ovr_cnt[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8-bit RXD receiver. Frame format, oversampling factor and stop-bit count are set by parameters. Each bit is decided by a 3-sample majority vote. Received words are delivered over a valid/ready handshake with parity, framing, break and overrun status. It sits between the pad-side rx line and the system-clock fabric, paced by an external oversample tick from the baud generator.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
OVS, 16, oversample ticks per bit, legal 8 or 16
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous active-high
bd_tick  in  1  one-cycle oversample enable, OVS per bit time
rx  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, valid while rx_valid
rx_valid  out  1  word available
rx_ready  in  1  consumer accepts word when rx_valid && rx_ready
parity_err  out  1  status of held word: parity mismatch
frame_err  out  1  status of held word: a stop bit sampled 0
overrun_err  out  1  one-cycle pulse: frame completed while rx_valid was high
break_det  out  1  one-cycle pulse: break frame detected

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous, active-high. Reset mid-frame aborts the frame and returns to IDLE.
- Reset values: rx_data=0; rx_valid, parity_err, frame_err, overrun_err and break_det all 0; state IDLE; both synchroniser flops =1, so no false edge is seen after reset.
- Input path: 2-flop synchroniser on every clk gives rx_s. A registered rx_prev is updated on bd_tick.
- Tick counter tick_cnt, width $clog2(OVS): advances only on bd_tick and runs 0..OVS-1 within each bit.
- Sampling: samples are taken at tick_cnt = OVS/2-1, OVS/2 and OVS/2+1. The bit value is the majority of the 3 samples, decided at OVS/2+1. The bit ends at OVS-1.
- State machine: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. All transitions happen on bd_tick only.
- IDLE: on a tick with rx_prev=1 and rx_s=0, go to START with tick_cnt=0.
- START: if the majority is 1 (false start/glitch), go to IDLE with no output. Otherwise go to DATA at bit end.
- DATA: shift the majority value in LSB first; a bit counter counts to DATA_BITS. Next state is PARITY if PARITY!=0, else STOP.
- PARITY: odd mode expects XOR(data, pbit)=1; even mode expects XOR(data, pbit)=0.
- STOP: STOP_BITS decisions; frame_err is set if any stop bit is 0.
- Completion: on the decision tick of the last stop bit the frame completes. The word and its status register in the next clk, so rx_valid rises 1 clk after that tick.
- After a good stop bit, go to IDLE. After a frame error, go to WAIT_IDLE.
- WAIT_IDLE: wait for a majority-1 bit time before returning to IDLE.
- Break: all data bits 0, parity bit 0 (if present) and the first stop bit 0. break_det pulses for 1 cycle, no word is delivered, and the state goes to WAIT_IDLE.
- Handshake: rx_valid stays high with rx_data, parity_err and frame_err stable until rx_valid && rx_ready. On that cycle rx_valid drops 1 clk later.
- Overrun: if a frame completes while rx_valid=1 and rx_ready=0 on the same cycle, the new word is dropped, the held word is kept and overrun_err pulses. If rx_ready=1 on that same cycle, the new word replaces the old one and there is no overrun.
- Ticks: bd_tick high on consecutive clocks is legal. With bd_tick held low the FSM freezes, but the handshake still operates.

Decomposition:
- Shared package uart_pkg: parity encodings PAR_NONE/PAR_ODD/PAR_EVEN, the state enum, and a status struct {parity_err, frame_err}.
- One sub-module, uart_bit_sampler: the synchroniser, rx_prev, the tick counter and the 3-sample majority vote. It outputs bit_value, bit_decide and bit_end strobes.

Test Plan:
- 8N1, OVS=16, send 0xA5 with clean ticks -> rx_valid 1 clk after the stop decision tick; rx_data=0xA5; parity_err=0, frame_err=0.
- 8O1, send 0x5A with parity bit 0 (correct is 1) -> rx_data=0x5A, parity_err=1. Resend with parity 1 -> parity_err=0.
- 9-bit 2-stop, send 0x1C3 with second stop=0 -> frame_err=1, then WAIT_IDLE. A following frame 0x055 is received cleanly after the line has been idle one bit time.
- Low glitch of 4 ticks on an idle line -> START aborts; no rx_valid, no errors.
- rx_ready held 0, send 0x11 then 0x22 -> rx_data stays 0x11; overrun_err pulses once when the second frame completes. Then assert rx_ready -> 0x11 consumed; rx_valid=0.
- Send 0x00 with stop=0 (break) -> break_det 1-cycle pulse, no rx_valid. Separately, assert rst mid-DATA -> all outputs 0 and the next frame 0x3C is received correctly.
